// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C bus sequencer: FSM/quarter encodings and
// the per-state SCL/SDA pull-down pattern.
package i2c_pkg;

    localparam int unsigned I2C_BYTE_W    = 8;
    localparam int unsigned I2C_BIT_IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP
    } i2c_state_e;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } i2c_qtr_e;

    localparam i2c_qtr_e ACK_SAMPLE_Q = Q2;

    // Returns {scl_oe, sda_oe}; 1 pulls the line low.
    function automatic logic [1:0] bus_oe(input i2c_state_e st, input i2c_qtr_e q,
                                          input logic data_bit);
        logic scl;
        logic sda;
        scl = 1'b0;
        sda = 1'b0;
        case (st)
            ST_START: begin
                scl = (q == Q2) || (q == Q3);
                sda = (q != Q0);
            end
            ST_BIT: begin
                scl = (q == Q0) || (q == Q3);
                sda = ~data_bit;
            end
            ST_ACK: begin
                scl = (q == Q0) || (q == Q3);
            end
            ST_STOP: begin
                scl = (q == Q0);
                sda = (q == Q0) || (q == Q1);
            end
            default: begin
                scl = 1'b0;
                sda = 1'b0;
            end
        endcase
        return {scl, sda};
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// QUARTER-clock divider: quarter index Q0..Q3 plus end-of-quarter and
// one-clock-early end-of-quarter strobes, all registered.
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int unsigned QUARTER = 250
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     restart_i,
    output i2c_qtr_e qtr_o,
    output logic     end_o,
    output logic     pre_end_o
);

    localparam int unsigned CNT_W = $clog2(QUARTER);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    i2c_qtr_e         qtr_q, qtr_d;
    logic             end_q, pre_end_q;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        qtr_d = qtr_q;
        if (restart_i) begin
            cnt_d = '0;
            qtr_d = Q0;
        end else if (end_q) begin
            cnt_d = '0;
            qtr_d = i2c_qtr_e'(qtr_q + 2'd1);
        end
    end

    // Strobes are decoded from the next count so they line up with cnt_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            qtr_q     <= Q0;
            end_q     <= 1'b0;
            pre_end_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            end_q     <= (cnt_d == CNT_W'(QUARTER - 1));
            pre_end_q <= (cnt_d == CNT_W'(QUARTER - 2));
        end
    end

    assign qtr_o     = qtr_q;
    assign end_o     = end_q;
    assign pre_end_o = pre_end_q;

endmodule

// File: rtl/i2c_bus_sequencer.sv
// Bit-level I2C master write engine: drives SCL/SDA and steps the external bit/msg/trans counters.
// Build option I2C_NACK_ABORT_EN: a NACK routes to STOP and ends the run.
module i2c_bus_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned QUARTER = 250
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     go,
    input  logic [I2C_BYTE_W-1:0]    byte_in,
    input  logic [I2C_BIT_IDX_W-1:0] index_bit,
    input  logic                     last_bit,
    input  logic                     last_msg,
    input  logic                     last_trans,
    input  logic                     sda_in,
    output logic                     inc_bit,
    output logic                     inc_msg,
    output logic                     inc_trans,
    output logic                     ctr_clear,
    output logic                     scl_oe,
    output logic                     sda_oe,
    output logic                     busy,
    output logic                     done,
    output logic                     nack
);

    i2c_state_e state_q, state_d;
    i2c_qtr_e   qtr, qtr_nxt;
    logic       qtr_end, qtr_pre_end;
    logic       slot_end, go_ok, ack_sample, data_bit, abort;
    logic       sda_s1_q, sda_s2_q;
    logic       nack_q, nack_d, done_q, done_d, busy_q, busy_d, clr_q, clr_d;
    logic       inc_bit_q, inc_bit_d, inc_msg_q, inc_msg_d, inc_trans_q, inc_trans_d;
    logic       scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;

    i2c_quarter_tick #(
        .QUARTER(QUARTER)
    ) u_tick (
        .clock    (clock),
        .reset    (reset),
        .restart_i(state_q == ST_IDLE),
        .qtr_o    (qtr),
        .end_o    (qtr_end),
        .pre_end_o(qtr_pre_end)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        nack_d      = nack_q;
        slot_end    = qtr_end && (qtr == Q3);
        go_ok       = (state_q == ST_IDLE) && go;
        ack_sample  = (state_q == ST_ACK) && (qtr == ACK_SAMPLE_Q) && qtr_end;
        data_bit    = byte_in[I2C_BIT_IDX_W'(I2C_BYTE_W - 1) - index_bit];
`ifdef I2C_NACK_ABORT_EN
        abort       = nack_q;
`else
        abort       = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE:  if (go) state_d = ST_START;
            ST_START: if (slot_end) state_d = ST_BIT;
            ST_BIT:   if (slot_end) state_d = last_bit ? ST_ACK : ST_BIT;
            ST_ACK:   if (slot_end) state_d = (last_msg || abort) ? ST_STOP : ST_BIT;
            ST_STOP:  if (slot_end) state_d = (last_trans || abort) ? ST_IDLE : ST_START;
            default:  state_d = ST_IDLE;
        endcase

        if (go_ok) begin
            nack_d = 1'b0;
        end else if (ack_sample && sda_s2_q) begin
            nack_d = 1'b1;
        end

        // Pulses land on the last clock of q3, so they are set up one clock early.
        inc_bit_d   = (state_q == ST_BIT)  && (qtr == Q3) && qtr_pre_end;
        inc_msg_d   = (state_q == ST_ACK)  && (qtr == Q3) && qtr_pre_end;
        inc_trans_d = (state_q == ST_STOP) && (qtr == Q3) && qtr_pre_end;
        done_d      = (state_q == ST_STOP) && (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        clr_d       = go_ok;

        qtr_nxt = qtr;
        if ((state_d != state_q) || (state_d == ST_IDLE)) begin
            qtr_nxt = Q0;
        end else if (qtr_end) begin
            qtr_nxt = i2c_qtr_e'(qtr + 2'd1);
        end
        // SDA data follows the counters one clock late; it settles while SCL is low in q0.
        {scl_oe_d, sda_oe_d} = bus_oe(state_d, qtr_nxt, data_bit);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sda_s1_q    <= 1'b0;
            sda_s2_q    <= 1'b0;
            nack_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            clr_q       <= 1'b0;
            inc_bit_q   <= 1'b0;
            inc_msg_q   <= 1'b0;
            inc_trans_q <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sda_s1_q    <= sda_in;
            sda_s2_q    <= sda_s1_q;
            nack_q      <= nack_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            clr_q       <= clr_d;
            inc_bit_q   <= inc_bit_d;
            inc_msg_q   <= inc_msg_d;
            inc_trans_q <= inc_trans_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign inc_bit   = inc_bit_q;
    assign inc_msg   = inc_msg_q;
    assign inc_trans = inc_trans_q;
    assign ctr_clear = clr_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign nack      = nack_q;

endmodule

// File: doc/i2c_bus_sequencer.md
# i2c_bus_sequencer

Bit-level I2C master write engine that drives SCL/SDA and steps the bit/message/transaction index counters of `i2c_message_controller_fsm`. It consumes the counters' `last_*` flags, pulses their `inc_*` inputs, and serialises `byte_in`, which an external ROM supplies combinationally from the current message and transaction indices. One `go` runs every transaction, 0..LIMIT_TRANS, back-to-back; each transaction is START, bytes 0..LIMIT_MSG, STOP.

## Interface
- `QUARTER`, default 250: clocks per quarter SCL period. 250 gives 100 kHz at 100 MHz. Legal minimum is 4.
- `clock` in, 1: sole clock.
- `reset` in, 1: synchronous, active-high.
- `go` in, 1: start a run. Sampled only in IDLE.
- `byte_in` in, 8: byte for the current message/transaction index.
- `index_bit` in, 3: bit index from the counter block.
- `last_bit`, `last_msg`, `last_trans` in, 1 each: counter limit flags.
- `inc_bit`, `inc_msg`, `inc_trans` out, 1 each: one-cycle counter increment pulses.
- `ctr_clear` out, 1: one-cycle pulse. The parent ORs it into the counter block's reset.
- `sda_in` in, 1: raw SDA pin. Synchronised internally by 2 flops.
- `scl_oe`, `sda_oe` out, 1 each: 1 pulls the line low; 0 releases it.
- `busy` out, 1: high from the first START cycle through the last STOP cycle.
- `done` out, 1: one-cycle pulse on the first IDLE cycle after a completed run.
- `nack` out, 1: sticky; any ACK slot sampled high. Cleared on an accepted `go`.

## Operation
- States: IDLE, START, BIT, ACK, STOP. Every non-IDLE state lasts 4 quarters, q0..q3.
- IDLE:
  - `scl_oe`=`sda_oe`=0.
  - `go` moves to START the next cycle.
  - `ctr_clear` is high during the first START cycle.
- START:
  - q0: SDA and SCL released.
  - q1: SDA low (the start condition).
  - q2–q3: SCL low.
  - Then BIT.
- BIT:
  - q0: SCL low; SDA driven with `byte_in[7-index_bit]` (MSB first).
  - q1–q2: SCL released.
  - q3: SCL low.
  - `inc_bit` pulses in the last clock of q3.
  - If `last_bit`, go to ACK; otherwise stay in BIT.
- ACK:
  - SDA released.
  - SCL pattern as in BIT.
  - Synchronised SDA is sampled in the last clock of q2; a high sample sets `nack`.
  - `inc_msg` pulses in the last clock of q3.
  - If `last_msg`, go to STOP; otherwise go to BIT.
- STOP:
  - q0: SCL low, SDA low.
  - q1: SCL released.
  - q2–q3: SDA released (the stop condition).
  - `inc_trans` pulses in the last clock of q3.
  - If `last_trans`, go to IDLE and pulse `done`; otherwise go to START.
- `last_*` are evaluated in the same cycle as the matching `inc_*`, i.e. against the pre-increment index.
- `go` while busy is ignored. `go` in the same cycle as `reset` is ignored.
- Reset mid-run:
  - Next edge: IDLE, lines released, `nack`=0.
  - No `inc_*` or `done` pulse is emitted.
  - The counters are resynchronised by `ctr_clear` on the next `go`.
- Reset values: every output is 0.

## Timing
- One quarter = exactly QUARTER clocks. The quarter counter restarts at 0 on every state entry.
- Byte = 9 slots × 4 quarters = 36·QUARTER clocks.
- Transaction = (8 + 36·(LIMIT_MSG+1))·QUARTER clocks.
- Run = (LIMIT_TRANS+1) × transaction.
- Cycle alignment:
  - `busy` rises one cycle after the accepted `go`.
  - `busy` falls the cycle `done` is high.
- ACK sampling latency: 2 flops, so the value sampled is the pin value from 2 clocks before the end of q2.

## Configuration
- `I2C_NACK_ABORT_EN` defined: a NACK in ACK routes to STOP regardless of `last_msg`.
  - After that STOP the run ends: IDLE with `done` pulsed, remaining transactions skipped.
  - `inc_msg`/`inc_trans` are still pulsed once each; counters may be left non-zero.
- Undefined: the NACK is only recorded in `nack`; the sequence continues unchanged.

## Structure
- `i2c_pkg`: state encoding, quarter enum (Q0..Q3), `I2C_BYTE_W`=8, ACK sample-quarter constant.
- Sub-module `i2c_quarter_tick`: QUARTER-clock divider. Outputs a quarter index plus an end-of-quarter strobe; restart input.
- Top instance: FSM, SDA synchroniser, `nack`/`done` registers.

## Test plan
- QUARTER=4, LIMIT_MSG=1, LIMIT_TRANS=0, slave ACKs, `go` once:
  - `busy` high 320 clocks.
  - 16 `inc_bit`, 2 `inc_msg`, 1 `inc_trans`, 1 `done`.
  - `nack`=0.
- `byte_in`=0xA5: SDA sampled at each SCL rise reads 1,0,1,0,0,1,0,1 then a released ACK slot. START shows SDA falling while SCL released; STOP shows SDA rising while SCL released.
- LIMIT_TRANS=2: three START/STOP pairs back-to-back, `done` only after the third STOP.
- Slave NACKs byte 0:
  - Without the macro: `nack`=1 and the full 320-clock run completes.
  - With `I2C_NACK_ABORT_EN`: STOP follows byte 0; `done` at clock (4+36+4)·4 = 176.
- `reset` asserted mid-BIT: next cycle `scl_oe`=`sda_oe`=`busy`=0. A new `go` pulses `ctr_clear` and completes normally.
- `go` pulsed while busy: no effect on the pulse counts or on `busy` duration.
